// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter in front of one registered W-bit adder, with a valid/ready response channel.
// Optional NIBBLE_ARB_SAT_EN: saturate the sum to all ones when the add carries out.
module nibble_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  // state  | meaning
  // S_IDLE | offer a grant to the round-robin winner, latch operands on accept
  // S_CALC | run the add, load the response registers
  // S_RESP | hold the response until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           any_valid;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IDW-1:0] id_q;
  logic [W:0]     sum_full;
  logic [W-1:0]   sum_out;

  // Search ptr+1 .. ptr; scanning downward lets the nearest valid index win.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW-1:0] pick;
    int idx;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, ptr);
  assign req_ready = (state == S_IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
  assign sum_full  = {1'b0, a_q} + {1'b0, b_q};

`ifdef NIBBLE_ARB_SAT_EN
  assign sum_out = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum_out = sum_full[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= IDW'(NREQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            a_q   <= req_a[int'(grant)*W +: W];
            b_q   <= req_b[int'(grant)*W +: W];
            id_q  <= grant;
            ptr   <= grant;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rsp_sum   <= sum_out;
          rsp_carry <= sum_full[W];
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Bench for nibble_add_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Honours NIBBLE_ARB_SAT_EN for the overflow expectation.
module tb_nibble_add_arbiter;
  localparam int NREQ = 4;
  localparam int W = 4;
  localparam int IDW = 2;
`ifdef NIBBLE_ARB_SAT_EN
  localparam bit SAT = 1'b1;
  localparam int EXP_OVF = 15;
`else
  localparam bit SAT = 1'b0;
  localparam int EXP_OVF = 3;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  nibble_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: one outstanding add, accepted at edge m_ta, response visible
  // from edge m_ta+1 until the first edge that sees rsp_ready.
  int             cyc = 0;
  bit             m_pend = 1'b0;
  int             m_ta = 0;
  int             m_ptr = NREQ - 1;
  int             m_id = 0;
  int             m_res = 0;
  logic [W-1:0]   e_sum = '0;
  logic           e_carry = 1'b0;
  logic [IDW-1:0] e_id = '0;
  int             grants[$];
  int             gcyc[$];

  function automatic int rr_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    if (m_pend) return '0;
    g = rr_winner(req_valid, m_ptr);
    if (g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  always @(posedge clk) begin
    int g;
    cyc = cyc + 1;
    if (reset) begin
      m_pend = 1'b0;
      m_ptr = NREQ - 1;
      e_sum = '0;
      e_carry = 1'b0;
      e_id = '0;
    end else if (m_pend) begin
      if (cyc == m_ta + 1) begin
        e_carry = (m_res >= 2 ** W);
        e_sum = (SAT && e_carry) ? {W{1'b1}} : W'(m_res % (2 ** W));
        e_id = IDW'(m_id);
      end else if (rsp_ready) begin
        m_pend = 1'b0;
      end
    end else begin
      g = rr_winner(req_valid, m_ptr);
      if (g >= 0) begin
        m_ptr = g;
        m_id = g;
        m_res = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
        m_ta = cyc;
        m_pend = 1'b1;
        grants.push_back(g);
        gcyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_pend && cyc >= m_ta + 1));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
      chk("rsp_carry", 32'(rsp_carry), 32'(e_carry));
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("ready_to_invalid", 32'(req_ready & ~req_valid), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int n, input string name);
    int t;
    t = 0;
    while (grants.size() < n && t < 20) begin
      tick();
      t++;
    end
    if (grants.size() < n) chk({name, "_timeout"}, 32'(grants.size()), 32'(n));
  endtask

  int e;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    started = 1'b1;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);

    // Single request from 2; neighbours carry junk operands
    set_req(2, 9, 5);
    req_a[3*W +: W] = 4'hx;
    req_b[1*W +: W] = 4'hx;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_sum", 32'(rsp_sum), 32'd14);
    chk("single_carry", 32'(rsp_carry), 32'd0);
    chk("single_id", 32'(rsp_id), 32'd2);
    tick();
    chk("single_one_cycle", 32'(rsp_valid), 32'd0);
    req_a = '0;
    req_b = '0;

    // Overflow from requester 1
    set_req(1, 12, 7);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    chk("ovf_carry", 32'(rsp_carry), 32'd1);
    chk("ovf_sum", 32'(rsp_sum), 32'(EXP_OVF));
    chk("ovf_id", 32'(rsp_id), 32'd1);
    tick();

    // Reset while the response is pending
    set_req(0, 3, 4);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
    chk("rst_pre_sum", 32'(rsp_sum), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid_cleared", 32'(rsp_valid), 32'd0);
    chk("rst_busy_cleared", 32'(busy), 32'd0);
    chk("rst_sum_cleared", 32'(rsp_sum), 32'd0);
    set_req(0, 1, 1);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("rst_after_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("rst_after_sum", 32'(rsp_sum), 32'd2);
    chk("rst_after_id", 32'(rsp_id), 32'd0);
    tick();

    // Round-robin with everyone waiting
    for (int i = 0; i < NREQ; i++) set_req(i, i + 2, i + 3);
    do_reset();
    grants.delete();
    gcyc.delete();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    wait_grants(6, "rr");
    req_valid = '0;
    if (grants.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % NREQ));
        if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
      end
    end
    tick();
    tick();
    tick();

    // Backpressure with others waiting
    do_reset();
    grants.delete();
    gcyc.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'd5);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    e = cyc;
    wait_grants(2, "bp");
    req_valid = '0;
    if (grants.size() >= 2) begin
      chk("bp_next_grant_id", 32'(grants[1]), 32'd1);
      chk("bp_next_grant_time", 32'(gcyc[1] - e), 32'd2);
    end
    tick();
    tick();
    tick();

    // Requester 3 drops while 1 is served
    do_reset();
    grants.delete();
    gcyc.delete();
    set_req(1, 4, 4);
    set_req(3, 6, 6);
    set_req(0, 5, 2);
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("drop_first_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0001;
    wait_grants(2, "drop");
    req_valid = '0;
    if (grants.size() >= 2) begin
      chk("drop_first", 32'(grants[0]), 32'd1);
      chk("drop_next", 32'(grants[1]), 32'd0);
    end
    tick();
    chk("drop_rsp_sum", 32'(rsp_sum), 32'd7);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
